hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_W, default 5, register-index width; register count is 2**REG_W.
REQ-002 Parameter DEPTH, default 2, number of downstream forwarding distances tracked (1 = MEM, 2 = WB, ...), minimum 1.
REQ-003 Parameter LOAD_LAT, default 1, extra cycles after EX before load data can be forwarded, range 0..DEPTH-1.
REQ-004 Parameter CNT_W, default 32, stall-counter width.
REQ-005 Port clk  input  1  rising-edge clock; the block is single-clock.
REQ-006 Port reset  input  1  asynchronous, active-low reset.
REQ-007 Port hold  input  1  global freeze, for example a memory wait.
REQ-008 Port flush  input  1  kills the instruction currently in ID (branch/jump/jr redirect).
REQ-009 Port id_valid  input  1  ID holds a real instruction.
REQ-010 Port id_rs, id_rt  input  REG_W each  source register indices.
REQ-011 Port id_use_rs, id_use_rt  input  1 each  the source is actually read.
REQ-012 Port id_wen  input  1  the instruction writes a register.
REQ-013 Port id_wreg  input  REG_W  destination register index.
REQ-014 Port id_is_load  input  1  the instruction is a load.
REQ-015 Port stall  output  1  hold PC and IF/ID, insert a bubble into ID/EX.
REQ-016 Port fwd_rs, fwd_rt  output  clog2(DEPTH+1) each  registered EX operand source: 0 = regfile/ID/EX value, d = producer d instructions older.
REQ-017 Port stall_cnt  output  CNT_W  saturating count of stall cycles.

Function
REQ-018 The block SHALL keep a shift register of DEPTH entries {valid, wreg, is_load}, where entry k holds the producer k slots ahead of the ID instruction.
REQ-019 A source SHALL match entry k only when valid=1, wreg equals the source index, the source index is nonzero, and the matching use flag is set.
REQ-020 For each source, only the youngest match (smallest k) SHALL count; older matches to the same register are ignored.
REQ-021 A match at k SHALL be ready when is_load=0, or when is_load=1 and k >= LOAD_LAT+1.
REQ-022 stall SHALL equal id_valid AND NOT flush AND (a youngest match on either source is not ready), and SHALL be combinational.
REQ-023 An issue SHALL occur on a rising edge when hold=0, id_valid=1, stall=0 and flush=0.
REQ-024 On issue, entry 1 SHALL load {id_wen AND id_wreg!=0, id_wreg, id_is_load}, entries shift k -> k+1, and entry DEPTH is discarded.
REQ-025 On issue, fwd_rs and fwd_rt SHALL register the youngest-match k of their source, or 0 when there is no match; latency from ID to output is one cycle.
REQ-026 On a rising edge with hold=0 and no issue (stall, flush or id_valid=0), the entries SHALL shift with a bubble (valid=0) into entry 1, and fwd_rs/fwd_rt SHALL register 0.
REQ-027 When flush and stall conditions coincide, flush SHALL win: stall=0, a bubble is inserted, and the counter is not incremented.
REQ-028 When hold=1, all entries, fwd_rs/fwd_rt and stall_cnt SHALL keep their values; stall is still driven but has no state effect.
REQ-029 stall_cnt SHALL increment by 1 on each edge with hold=0 and stall=1, and SHALL saturate at 2**CNT_W-1 without wrapping.
REQ-030 A producer that shifts beyond DEPTH SHALL be considered written to the regfile; the external WB write-through bypass covers it, so fwd=0.
REQ-031 A producer with id_wen=1 and id_wreg=0 SHALL never cause a stall or a forward.

Reset
REQ-032 While reset=0, all entry valid bits, fwd_rs, fwd_rt and stall_cnt SHALL be 0 immediately, independent of clk.
REQ-033 Assertion of reset mid-stall SHALL clear all hazards, so stall falls to 0 combinationally because no entry is valid.
REQ-034 The first issue SHALL be possible on the first rising edge after reset returns to 1.

Verification
REQ-035 Load-use case (defaults): issue lw $8, then next cycle add using rs=$8 -> stall=1 for exactly 1 cycle, stall_cnt=1, add issues with fwd_rs=2.
REQ-036 ALU chain: add $3 followed by sub using rs=$3, rt=$3 -> no stall, fwd_rs=fwd_rt=1; with one unrelated instruction between them -> fwd=2; with two between -> fwd=0.
REQ-037 Youngest wins: add $5, then lw $5, then a consumer of $5 -> stall 1 cycle, then fwd_rs=2 (the load), not the older add.
REQ-038 $0 and flush: lw $0 then a consumer of $0 -> no stall, fwd=0; a load-use pair with flush=1 on the consumer cycle -> stall=0, bubble inserted, stall_cnt unchanged.
REQ-039 Hold, saturation and reset: hold=1 for 3 cycles during a stall -> entries and stall_cnt frozen; with CNT_W=2, 5 stall cycles -> stall_cnt=3; reset pulled low mid-sequence -> all outputs 0 asynchronously.
REQ-040 Parameter sweep DEPTH=4, LOAD_LAT=2: lw $9 then consumer of $9 -> 2 stall cycles, then fwd_rs=3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage RAW hazard detection with load-use stall,
// registered EX forwarding selects and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32,
    localparam int FW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wen,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             id_is_load,
    output logic             stall,
    output logic [FW-1:0]    fwd_rs,
    output logic [FW-1:0]    fwd_rt,
    output logic [CNT_W-1:0] stall_cnt
);
    logic [DEPTH:1]   v, ld;
    logic [REG_W-1:0] w [1:DEPTH];
    logic [FW-1:0]    rs_k, rt_k;
    logic             rs_rdy, rt_rdy, issue;

    // scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        rs_k   = '0;
        rt_k   = '0;
        rs_rdy = 1'b1;
        rt_rdy = 1'b1;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_use_rs && id_rs != '0 && v[k] && w[k] == id_rs) begin
                rs_k   = FW'(k);
                rs_rdy = !ld[k] || k >= LOAD_LAT + 1;
            end
            if (id_use_rt && id_rt != '0 && v[k] && w[k] == id_rt) begin
                rt_k   = FW'(k);
                rt_rdy = !ld[k] || k >= LOAD_LAT + 1;
            end
        end
    end

    assign stall = id_valid && !flush && !(rs_rdy && rt_rdy);
    assign issue = !hold && id_valid && !flush && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            ld        <= '0;
            fwd_rs    <= '0;
            fwd_rt    <= '0;
            stall_cnt <= '0;
            for (int k = 1; k <= DEPTH; k++) w[k] <= '0;
        end else if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                v[k]  <= v[k-1];
                ld[k] <= ld[k-1];
                w[k]  <= w[k-1];
            end
            v[1]   <= issue && id_wen && id_wreg != '0;
            ld[1]  <= id_is_load;
            w[1]   <= id_wreg;
            fwd_rs <= issue ? rs_k : '0;
            fwd_rt <= issue ? rt_k : '0;
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule
